cga_mic_stack_ctl: RTL and testbench
====================================

Name: cga_mic_stack_ctl

Overview:
- Sequencer for the 4-deep microprogram return stack (the 16 bit-slices of /CGA/MIC/STACK).
- Accepts PUSH / POP / REPLACE commands from microsequencer logic and drives the shared slice controls: S3, S3N, S4S3N, S4NS3N, LOAD and the stack-clock enable.
- Tracks occupancy and reports EMPTY/FULL plus sticky overflow/underflow flags.
- Every operation is split into a select-setup cycle and a clock cycle, so slice selects are stable before the stack shift edge.

Parameters:
- DEPTH_MAX, 4, number of stack levels in the slices.
- CNTW, 3, width of the occupancy counter; must satisfy 2^CNTW > DEPTH_MAX.

Ports:
- MCLK  in  1  system clock; all state changes on its rising edge.
- RST  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command request.
- CMD  in  2  command code: 00 NOP, 01 PUSH, 10 POP, 11 REPLACE top.
- CMD_READY  out  1  controller idle; a command is accepted when CMD_VALID & CMD_READY at an edge.
- DONE  out  1  one-cycle pulse in the SHIFT cycle of every accepted non-NOP command.
- CLRFLG  in  1  clears OVF and UNF.
- S3  out  1  slice select: shift up (pop path).
- S3N  out  1  always the complement of S3.
- S4S3N  out  1  top entry taken from STIN.
- S4NS3N  out  1  top entry recirculates STOUT.
- LOAD  out  1  slice parallel load (1) vs serial shift from SI (0).
- SCLKEN  out  1  enable gating the stack clock SCLKN for one cycle.
- DEPTH  out  CNTW  current occupancy, 0..DEPTH_MAX.
- EMPTY  out  1  DEPTH == 0.
- FULL  out  1  DEPTH == DEPTH_MAX.
- OVF  out  1  sticky: push attempted while FULL.
- UNF  out  1  sticky: pop attempted while EMPTY.

Behaviour:
- Reset, and idle output state (HOLD encoding):
  - State IDLE.
  - S3=0, S3N=1, S4S3N=0, S4NS3N=1, LOAD=1.
  - SCLKEN=0, DONE=0, CMD_READY=1.
  - DEPTH=0, EMPTY=1, FULL=0, OVF=0, UNF=0.
- Select encodings, all registered outputs:
  - HOLD: S3=0, S4S3N=0, S4NS3N=1, LOAD=1.
  - PUSH: S3=0, S4S3N=1, S4NS3N=0, LOAD=0. Serial shift down; new top comes from STIN; the deepest entry is lost.
  - POP: S3=1, S4S3N=0, S4NS3N=0, LOAD=1. Shift up.
  - REPLACE: S3=0, S4S3N=1, S4NS3N=0, LOAD=1. Top loaded from STIN; lower levels hold.
  - S4S3N and S4NS3N are never both 1.
- State machine:
  - IDLE -> SETUP on acceptance of a non-NOP command. The command is latched.
  - NOP acceptance is a no-op and stays in IDLE.
  - SETUP: CMD_READY=0; selects driven to the latched command encoding; SCLKEN=0.
  - SETUP -> SHIFT unconditionally.
  - SHIFT: selects held; SCLKEN=1 (except pop-on-empty, below); DONE=1. DEPTH and flags update at the closing edge.
  - SHIFT -> IDLE; selects return to HOLD; CMD_READY=1.
- Latency and throughput:
  - Accept edge -> SETUP -> SHIFT -> IDLE.
  - One command per 3 cycles; DONE occurs 2 cycles after the accept edge.
  - CMD/CMD_VALID are ignored while not IDLE.
- Occupancy rules:
  - PUSH: DEPTH+1, saturating at DEPTH_MAX. Push while FULL still shifts (SCLKEN=1), keeps DEPTH=DEPTH_MAX and sets OVF.
  - POP: DEPTH-1. Pop while EMPTY sequences SETUP/SHIFT with DONE=1 but SCLKEN=0; DEPTH stays 0 and UNF is set.
  - REPLACE: DEPTH unchanged, except from 0 it becomes 1.
- Flags:
  - CLRFLG clears OVF/UNF at the next edge.
  - CLRFLG coincident with a setting event: set wins.
- Reset mid-operation: RST at any edge returns all outputs to the reset values at that edge. SCLKEN is never 1 in the cycle after an RST edge, and the interrupted command has no DEPTH effect.

Test Plan:
- RST, then PUSH x4 spaced at READY -> DEPTH 1,2,3,4; FULL=1 after the 4th. Each op shows SCLKEN=1 for exactly one cycle, 2 cycles after accept, with S4S3N=1 and LOAD=0 during SETUP and SHIFT.
- From FULL, PUSH -> SCLKEN pulses, DEPTH stays 4, OVF=1. Then CLRFLG -> OVF=0. CLRFLG together with a 2nd overflowing push -> OVF=1.
- From DEPTH=2, POP x3 -> DEPTH 1,0,0. The 3rd pop has DONE=1, SCLKEN=0, UNF=1; S3=1 and S3N=0 during active cycles.
- REPLACE at DEPTH=0 -> DEPTH=1, LOAD=1, S4S3N=1. REPLACE at DEPTH=3 -> DEPTH=3.
- CMD_VALID held high with alternating commands -> accepts only when CMD_READY=1; NOP accepted without leaving IDLE; selects read HOLD in every IDLE cycle.
- RST asserted in the SETUP cycle of a PUSH at DEPTH=2 -> next cycle DEPTH=0, SCLKEN=0, CMD_READY=1, HOLD encoding.

Source files
------------

// File: rtl/cga_mic_stack_ctl.sv
// cga_mic_stack_ctl
// Sequencer for the 4-deep microprogram return stack built from 16 bit-slices.
// Each accepted PUSH / POP / REPLACE runs for two cycles. In SETUP the slice
// selects are driven. In SHIFT the stack clock is enabled. This keeps the
// selects stable before the shift edge.
//
// Ports:
//   MCLK       system clock, rising edge
//   RST        synchronous active-high reset
//   CMD_VALID  command request
//   CMD        00 NOP, 01 PUSH, 10 POP, 11 REPLACE top
//   CMD_READY  controller idle; accept on CMD_VALID & CMD_READY
//   DONE       one-cycle pulse in the SHIFT cycle of a non-NOP command
//   CLRFLG     clears OVF / UNF (a coincident set wins)
//   S3, S3N    shift-up select and its complement
//   S4S3N      top entry from STIN
//   S4NS3N     top entry recirculates STOUT
//   LOAD       parallel load (1) / serial shift from SI (0)
//   SCLKEN     one-cycle enable for the stack clock
//   DEPTH      occupancy 0..DEPTH_MAX
//   EMPTY      DEPTH == 0
//   FULL       DEPTH == DEPTH_MAX
//   OVF        sticky: push attempted while FULL
//   UNF        sticky: pop attempted while EMPTY
module cga_mic_stack_ctl #(
    parameter int DEPTH_MAX = 4,
    parameter int CNTW      = 3
) (
    input  logic            MCLK,
    input  logic            RST,
    input  logic            CMD_VALID,
    input  logic [1:0]      CMD,
    output logic            CMD_READY,
    output logic            DONE,
    input  logic            CLRFLG,
    output logic            S3,
    output logic            S3N,
    output logic            S4S3N,
    output logic            S4NS3N,
    output logic            LOAD,
    output logic            SCLKEN,
    output logic [CNTW-1:0] DEPTH,
    output logic            EMPTY,
    output logic            FULL,
    output logic            OVF,
    output logic            UNF
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_REPL = 2'b11
    } op_t;

    localparam logic [CNTW-1:0] DMAX = CNTW'(DEPTH_MAX);

    // Select bundle order: {S3, S3N, S4S3N, S4NS3N, LOAD}
    localparam logic [4:0] SEL_HOLD = 5'b01011;
    localparam logic [4:0] SEL_PUSH = 5'b01100;
    localparam logic [4:0] SEL_POP  = 5'b10001;
    localparam logic [4:0] SEL_REPL = 5'b01101;

    state_t          state;
    op_t             op_q;
    logic [CNTW-1:0] depth_nxt;
    logic            ovf_set;
    logic            unf_set;

    // Occupancy and flag effects of the command now in SHIFT. They are
    // committed at the edge that closes SHIFT.
    always_comb begin
        depth_nxt = DEPTH;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        if (state == ST_SHIFT) begin
            case (op_q)
                OP_PUSH: begin
                    if (FULL) ovf_set = 1'b1;
                    else      depth_nxt = DEPTH + 1'b1;
                end
                OP_POP: begin
                    if (EMPTY) unf_set = 1'b1;
                    else       depth_nxt = DEPTH - 1'b1;
                end
                OP_REPL: begin
                    if (EMPTY) depth_nxt = CNTW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge MCLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            op_q      <= OP_NOP;
            {S3, S3N, S4S3N, S4NS3N, LOAD} <= SEL_HOLD;
            SCLKEN    <= 1'b0;
            DONE      <= 1'b0;
            CMD_READY <= 1'b1;
            DEPTH     <= '0;
            EMPTY     <= 1'b1;
            FULL      <= 1'b0;
            OVF       <= 1'b0;
            UNF       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (CMD_VALID && (CMD != OP_NOP)) begin
                        state     <= ST_SETUP;
                        op_q      <= op_t'(CMD);
                        CMD_READY <= 1'b0;
                        case (CMD)
                            OP_PUSH: {S3, S3N, S4S3N, S4NS3N, LOAD} <= SEL_PUSH;
                            OP_POP:  {S3, S3N, S4S3N, S4NS3N, LOAD} <= SEL_POP;
                            default: {S3, S3N, S4S3N, S4NS3N, LOAD} <= SEL_REPL;
                        endcase
                    end
                end
                ST_SETUP: begin
                    state  <= ST_SHIFT;
                    DONE   <= 1'b1;
                    // A pop on an empty stack still sequences, but the
                    // slices must not shift.
                    SCLKEN <= !((op_q == OP_POP) && EMPTY);
                end
                ST_SHIFT: begin
                    state     <= ST_IDLE;
                    DONE      <= 1'b0;
                    SCLKEN    <= 1'b0;
                    CMD_READY <= 1'b1;
                    {S3, S3N, S4S3N, S4NS3N, LOAD} <= SEL_HOLD;
                end
                default: begin
                    state     <= ST_IDLE;
                    DONE      <= 1'b0;
                    SCLKEN    <= 1'b0;
                    CMD_READY <= 1'b1;
                    {S3, S3N, S4S3N, S4NS3N, LOAD} <= SEL_HOLD;
                end
            endcase

            DEPTH <= depth_nxt;
            EMPTY <= (depth_nxt == '0);
            FULL  <= (depth_nxt == DMAX);
            // Set has priority over a coincident clear.
            OVF   <= ovf_set | (OVF & ~CLRFLG);
            UNF   <= unf_set | (UNF & ~CLRFLG);
        end
    end

endmodule

// File: tb/tb_cga_mic_stack_ctl.sv
// Self-checking bench for cga_mic_stack_ctl.
// Inputs change on the falling edge. The DUT and the reference model both
// sample on the rising edge. Outputs are compared on the falling edge.
module tb_cga_mic_stack_ctl;

    localparam int DMAX = 4;

    logic       MCLK      = 1'b0;
    logic       RST       = 1'b1;
    logic       CMD_VALID = 1'b0;
    logic [1:0] CMD       = 2'b00;
    logic       CLRFLG    = 1'b0;
    logic       CMD_READY, DONE, S3, S3N, S4S3N, S4NS3N, LOAD, SCLKEN;
    logic       EMPTY, FULL, OVF, UNF;
    logic [2:0] DEPTH;

    cga_mic_stack_ctl #(.DEPTH_MAX(4), .CNTW(3)) dut (
        .MCLK(MCLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD(CMD),
        .CMD_READY(CMD_READY), .DONE(DONE), .CLRFLG(CLRFLG),
        .S3(S3), .S3N(S3N), .S4S3N(S4S3N), .S4NS3N(S4NS3N), .LOAD(LOAD),
        .SCLKEN(SCLKEN), .DEPTH(DEPTH), .EMPTY(EMPTY), .FULL(FULL),
        .OVF(OVF), .UNF(UNF)
    );

    always #5 MCLK = ~MCLK;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model. A command accepted at rising edge number acc is in
    // its select phase during the cycle after that edge (age 0). It is in
    // its clock phase during the next cycle (age 1). Its occupancy effect
    // lands at the edge that ends age 1.
    int         cyc    = 0;
    int         acc    = -10;
    int         mdepth = 0;
    bit         movf   = 1'b0;
    bit         munf   = 1'b0;
    logic [1:0] mcmd   = 2'b00;
    // {S3, S4S3N, S4NS3N, LOAD} per command code; index 0 is HOLD
    logic [3:0] enc_tab [4] = '{4'b0011, 4'b0100, 4'b1001, 4'b0101};

    always @(posedge MCLK) begin : model
        int age;
        age = cyc - acc;
        if (RST) begin
            acc    = -10;
            mdepth = 0;
            movf   = 1'b0;
            munf   = 1'b0;
        end else begin
            if (CLRFLG) begin
                movf = 1'b0;
                munf = 1'b0;
            end
            if (age == 1) begin
                case (mcmd)
                    2'b01: if (mdepth == DMAX) movf = 1'b1; else mdepth = mdepth + 1;
                    2'b10: if (mdepth == 0) munf = 1'b1; else mdepth = mdepth - 1;
                    2'b11: if (mdepth == 0) mdepth = 1;
                    default: ;
                endcase
            end
            if (age != 0 && age != 1 && CMD_VALID && CMD != 2'b00) begin
                acc  = cyc + 1;
                mcmd = CMD;
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge MCLK) begin : compare
        int         age;
        bit         active;
        logic [3:0] enc;
        if (chk_en) begin
            age    = cyc - acc;
            active = (age == 0) || (age == 1);
            enc    = active ? enc_tab[mcmd] : enc_tab[0];
            check("s3",      S3,        enc[3]);
            check("s3n",     S3N,       !enc[3]);
            check("s4s3n",   S4S3N,     enc[2]);
            check("s4ns3n",  S4NS3N,    enc[1]);
            check("load",    LOAD,      enc[0]);
            check("sclken",  SCLKEN,    (age == 1) && !(mcmd == 2'b10 && mdepth == 0));
            check("done",    DONE,      age == 1);
            check("ready",   CMD_READY, !active);
            check("depth",   DEPTH,     8'(mdepth));
            check("empty",   EMPTY,     mdepth == 0);
            check("full",    FULL,      mdepth == DMAX);
            check("ovf",     OVF,       movf);
            check("unf",     UNF,       munf);
        end
    end

    // Called on a falling edge while idle. Returns on the falling edge where
    // the controller is idle again.
    task automatic do_op(input string name, input logic [1:0] c,
                         input int exp_depth, input logic exp_sclk);
        CMD_VALID = 1'b1;
        CMD       = c;
        @(negedge MCLK);
        CMD_VALID = 1'b0;
        CMD       = 2'b00;
        check({name, "_setup_ready"}, CMD_READY, 1'b0);
        check({name, "_setup_sclk"}, SCLKEN, 1'b0);
        @(negedge MCLK);
        check({name, "_done"}, DONE, 1'b1);
        check({name, "_sclk"}, SCLKEN, exp_sclk);
        @(negedge MCLK);
        check({name, "_depth"}, DEPTH, 8'(exp_depth));
        check({name, "_ready"}, CMD_READY, 1'b1);
    endtask

    task automatic pulse_clr();
        CLRFLG = 1'b1;
        @(negedge MCLK);
        CLRFLG = 1'b0;
    endtask

    logic [1:0] alt_seq [13] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01,
                                 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        @(posedge MCLK);
        @(posedge MCLK);
        #1 chk_en = 1'b1;
        @(negedge MCLK);
        check("rst_ready", CMD_READY, 1'b1);
        check("rst_depth", DEPTH, 8'd0);
        check("rst_empty", EMPTY, 1'b1);
        check("rst_load",  LOAD, 1'b1);
        RST = 1'b0;

        // fill the stack
        do_op("push1", 2'b01, 1, 1'b1);
        do_op("push2", 2'b01, 2, 1'b1);
        do_op("push3", 2'b01, 3, 1'b1);
        do_op("push4", 2'b01, 4, 1'b1);
        check("full_after4", FULL, 1'b1);

        // overflow, clear, and clear racing a second overflow
        do_op("push_ovf", 2'b01, 4, 1'b1);
        check("ovf_set", OVF, 1'b1);
        pulse_clr();
        check("ovf_clr", OVF, 1'b0);
        CLRFLG = 1'b1;
        do_op("push_ovf_clr", 2'b01, 4, 1'b1);
        CLRFLG = 1'b0;
        check("ovf_set_wins", OVF, 1'b1);
        pulse_clr();

        // pops down past empty
        do_op("pop_a", 2'b10, 3, 1'b1);
        do_op("pop_b", 2'b10, 2, 1'b1);
        do_op("pop_c", 2'b10, 1, 1'b1);
        do_op("pop_d", 2'b10, 0, 1'b1);
        do_op("pop_unf", 2'b10, 0, 1'b0);
        check("unf_set", UNF, 1'b1);
        check("ovf_clear_kept", OVF, 1'b0);
        pulse_clr();
        check("unf_clr", UNF, 1'b0);

        // replace
        do_op("repl_empty", 2'b11, 1, 1'b1);
        do_op("push_r1", 2'b01, 2, 1'b1);
        do_op("push_r2", 2'b01, 3, 1'b1);
        do_op("repl_3", 2'b11, 3, 1'b1);

        // CMD_VALID held high; only idle cycles accept
        CMD_VALID = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i == 1) check("nop_stays_idle", CMD_READY, 1'b1);
            CMD = alt_seq[i];
            @(negedge MCLK);
        end
        CMD_VALID = 1'b0;
        CMD       = 2'b00;
        repeat (3) @(negedge MCLK);
        check("alt_depth", DEPTH, 8'd3);

        // reset in the select phase of a push at depth 2
        do_op("pop_pre_rst", 2'b10, 2, 1'b1);
        CMD_VALID = 1'b1;
        CMD       = 2'b01;
        @(negedge MCLK);
        CMD_VALID = 1'b0;
        CMD       = 2'b00;
        check("rstmid_setup_s4s3n", S4S3N, 1'b1);
        check("rstmid_setup_load",  LOAD, 1'b0);
        RST = 1'b1;
        @(negedge MCLK);
        check("rstmid_depth",  DEPTH, 8'd0);
        check("rstmid_sclk",   SCLKEN, 1'b0);
        check("rstmid_ready",  CMD_READY, 1'b1);
        check("rstmid_s4ns3n", S4NS3N, 1'b1);
        check("rstmid_load",   LOAD, 1'b1);
        RST = 1'b0;
        repeat (4) @(negedge MCLK);
        check("rstmid_after_depth", DEPTH, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
